sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single external 8-bit asynchronous SRAM (256K x 8) between two requesters: the 6502 CPU port and a read-only video fetch port feeding the 6847 VDG. It runs entirely in the clk100 domain and sequences RAMCS_b/RAMOE_b/RAMWE_b, the address bus and the data-pin output enable, with round-robin arbitration. It sits between the CPU/VDG glue logic and the SB_IO data-pin instances at the top level.

## Interface
- ADDR_W, 18: SRAM address width.
- RD_CYCLES, 2: clk100 cycles RAMOE_b is held low per read; legal range 1-15.
- WE_CYCLES, 2: clk100 cycles RAMWE_b is held low per write; legal range 1-15.

Ports:
- clk100  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request, level; held until cpu_ack.
- cpu_rnw  in  1  1 = read, 0 = write; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid while cpu_ack is high, held afterwards.
- cpu_ack  out  1  one-cycle completion pulse.
- vid_req  in  1  video read request, level; held until vid_ack.
- vid_addr  in  ADDR_W  video address.
- vid_rdata  out  8  read data; valid while vid_ack is high, held afterwards.
- vid_ack  out  1  one-cycle completion pulse.
- RAMCS_b, RAMOE_b, RAMWE_b  out  1  SRAM strobes, active low.
- ADR  out  ADDR_W  SRAM address.
- dat_out  out  8  data to the pins.
- dat_oe  out  1  pin output enable.
- dat_in  in  8  data from the pins.

## Operation
- All outputs are registered. Reset values: RAMCS_b=1, RAMOE_b=1, RAMWE_b=1, ADR=0, dat_out=0, dat_oe=0, cpu_ack=0, vid_ack=0, cpu_rdata=0, vid_rdata=0, last_grant=CPU.
- FSM states: IDLE, READ, WR_SETUP, WR_PULSE, DONE.
- IDLE:
  - Samples cpu_req and vid_req.
  - If exactly one is high, that requester is granted.
  - If both are high, the requester not in last_grant is granted. After reset this is video.
  - On grant, last_grant is updated and ADR is loaded. RAMCS_b goes to 0.
  - Video grants and CPU reads: RAMOE_b goes to 0, counter = RD_CYCLES-1, next state READ.
  - CPU writes: dat_out=cpu_wdata, dat_oe=1, next state WR_SETUP.
- READ:
  - Counter decrements each cycle.
  - At count 0: dat_in is captured into the owner's rdata, the owner's ack is set to 1, RAMOE_b=1, RAMCS_b=1, next state DONE.
- WR_SETUP: RAMWE_b goes to 0, counter = WE_CYCLES-1, next state WR_PULSE.
- WR_PULSE:
  - Counter decrements each cycle.
  - At count 0: RAMWE_b=1, cpu_ack=1, next state DONE.
  - dat_oe stays 1 through DONE to provide data hold.
- DONE:
  - ack=0, dat_oe=0, RAMCS_b=1, next state IDLE.
  - Requests are not sampled in DONE.
- Handshake:
  - The requester drops req on the edge where it sees ack high.
  - A req that is still high in IDLE after DONE counts as a new request.
  - Address, rnw and wdata must stay stable from req rising until ack.
- RAMWE_b and RAMOE_b are never low in the same cycle. dat_oe is never 1 while RAMOE_b=0.
- Reset asserted mid-transaction: all outputs go to their reset values immediately (asynchronous), the state returns to IDLE and no ack is issued.

## Timing
- Grant edge = E0.
- Read: RAMOE_b is low for exactly RD_CYCLES cycles, from after E0 through E_RD_CYCLES. The ack is high in the cycle after E_RD_CYCLES. Occupancy is RD_CYCLES+2 cycles, including IDLE.
- Write:
  - 1 setup cycle with address and data valid and RAMWE_b=1.
  - WE_CYCLES cycles with RAMWE_b=0.
  - 1 hold/ack cycle.
  - Occupancy is WE_CYCLES+3 cycles.
- Worst-case video latency from req to ack, with defaults: one CPU write (5) plus its own read (4) = 9 clk100 cycles. This is well inside one VDG byte slot at 25 MHz x 2.
- At most one outstanding transaction per port; no pipelining.

## Structure
- Shared package atom_sram_pkg holds:
  - the FSM state encoding (IDLE, READ, WR_SETUP, WR_PULSE, DONE);
  - GRANT_CPU/GRANT_VID constants;
  - default timing constants RD_CYCLES_DEF=2 and WE_CYCLES_DEF=2.
- The block is flat; no sub-module. The round-robin picker is two gates and the counter is 4 bits.
- Top-level integration instantiates SB_IO for the data pins from dat_out/dat_oe/dat_in.

## Test plan
- CPU read: cpu_addr=0x00123, SRAM model holds 0x5A, defaults → RAMOE_b low exactly 2 cycles, cpu_ack 1-cycle pulse, cpu_rdata=0x5A, vid_ack stays 0.
- CPU write: cpu_addr=0x3FFFF, wdata=0xA5 → 1 setup cycle, RAMWE_b low 2 cycles, data driven through the ack cycle, model location = 0xA5, RAMOE_b=1 throughout.
- Simultaneous requests after reset: cpu_req and vid_req rise together → video is served first, then CPU; repeat both held → strict alternation VID, CPU, VID, CPU.
- Back-to-back: video keeps req high across its ack → a second read starts after DONE, with no duplicate ack in DONE; the CPU is not starved (served next).
- Reset mid-write: assert reset during WR_PULSE → RAMWE_b=1 and dat_oe=0 in the same cycle, no cpu_ack; after release, a fresh CPU read completes normally.
- Parameter sweep: RD_CYCLES=1, WE_CYCLES=4 → OE low width 1, WE low width 4, occupancy 3 and 7 cycles respectively.

Source files
------------

// File: rtl/atom_sram_pkg.sv
// Shared types and defaults for the external SRAM arbiter.
// State encoding, grant identifiers and strobe timing defaults.
package atom_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WR_SETUP,
    WR_PULSE,
    DONE
  } state_e;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_VID = 1'b1;

  localparam int RD_CYCLES_DEF = 2;
  localparam int WE_CYCLES_DEF = 2;

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin sharing of one async 8-bit SRAM between CPU and video.
// All SRAM strobes, address, data and acks come straight from flops.
module sram_arbiter
  import atom_sram_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int RD_CYCLES = RD_CYCLES_DEF,
  parameter int WE_CYCLES = WE_CYCLES_DEF
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_rdata,
  output logic              vid_ack,
  output logic              RAMCS_b,
  output logic              RAMOE_b,
  output logic              RAMWE_b,
  output logic [ADDR_W-1:0] ADR,
  output logic [7:0]        dat_out,
  output logic              dat_oe,
  input  logic [7:0]        dat_in
);

  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cs_q, cs_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [7:0]        dout_q, dout_d;
  logic              doe_q, doe_d;
  logic              cack_q, cack_d;
  logic              vack_q, vack_d;
  logic [7:0]        crd_q, crd_d;
  logic [7:0]        vrd_q, vrd_d;
  logic              pick_vid;

  // Video wins when alone, or when both ask and the CPU went last.
  assign pick_vid = vid_req & (~cpu_req | (grant_q == GRANT_CPU));

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= GRANT_CPU;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      adr_q   <= '0;
      dout_q  <= '0;
      doe_q   <= 1'b0;
      cack_q  <= 1'b0;
      vack_q  <= 1'b0;
      crd_q   <= '0;
      vrd_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      cack_q  <= cack_d;
      vack_q  <= vack_d;
      crd_q   <= crd_d;
      vrd_q   <= vrd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    oe_d    = oe_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dout_d  = dout_q;
    doe_d   = doe_q;
    cack_d  = 1'b0;
    vack_d  = 1'b0;
    crd_d   = crd_q;
    vrd_d   = vrd_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req | vid_req) begin
          cs_d = 1'b0;
          if (pick_vid) begin
            grant_d = GRANT_VID;
            adr_d   = vid_addr;
            oe_d    = 1'b0;
            cnt_d   = RD_LOAD;
            state_d = READ;
          end else begin
            grant_d = GRANT_CPU;
            adr_d   = cpu_addr;
            if (cpu_rnw) begin
              oe_d    = 1'b0;
              cnt_d   = RD_LOAD;
              state_d = READ;
            end else begin
              dout_d  = cpu_wdata;
              doe_d   = 1'b1;
              state_d = WR_SETUP;
            end
          end
        end
      end
      READ: begin
        if (cnt_q == 4'd0) begin
          if (grant_q == GRANT_VID) begin
            vrd_d  = dat_in;
            vack_d = 1'b1;
          end else begin
            crd_d  = dat_in;
            cack_d = 1'b1;
          end
          oe_d    = 1'b1;
          cs_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_SETUP: begin
        we_d    = 1'b0;
        cnt_d   = WE_LOAD;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        // CS and dat_oe stay asserted into DONE for data hold.
        if (cnt_q == 4'd0) begin
          we_d    = 1'b1;
          cack_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        doe_d   = 1'b0;
        cs_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign RAMCS_b   = cs_q;
  assign RAMOE_b   = oe_q;
  assign RAMWE_b   = we_q;
  assign ADR       = adr_q;
  assign dat_out   = dout_q;
  assign dat_oe    = doe_q;
  assign cpu_ack   = cack_q;
  assign vid_ack   = vack_q;
  assign cpu_rdata = crd_q;
  assign vid_rdata = vrd_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed tables, corner sequences, random traffic.
// Two instances: default timing and a short-read/long-write variant.
module tb_sram_arbiter;

  localparam int AW = 18;
  localparam logic [AW-1:0] BASE = 18'h01000;

  logic clk = 1'b0;
  logic rst;

  logic          cpu_req0, cpu_rnw0, cpu_ack0;
  logic [AW-1:0] cpu_addr0;
  logic [7:0]    cpu_wdata0, cpu_rdata0;
  logic          vid_req0, vid_ack0;
  logic [AW-1:0] vid_addr0;
  logic [7:0]    vid_rdata0;
  logic          cs0, oe0, we0, doe0;
  logic [AW-1:0] adr0;
  logic [7:0]    dout0, din0;

  logic          cpu_req1, cpu_rnw1, cpu_ack1;
  logic [AW-1:0] cpu_addr1;
  logic [7:0]    cpu_wdata1, cpu_rdata1;
  logic          vid_req1, vid_ack1;
  logic [AW-1:0] vid_addr1;
  logic [7:0]    vid_rdata1;
  logic          cs1, oe1, we1, doe1;
  logic [AW-1:0] adr1;
  logic [7:0]    dout1, din1;

  bit [7:0] mem0 [0:(1<<AW)-1];
  bit [7:0] mem1 [0:(1<<AW)-1];

  always #5 clk = ~clk;

  // Async SRAM: data visible only while selected and output-enabled.
  assign din0 = (!cs0 && !oe0) ? mem0[adr0] : 8'hEE;
  assign din1 = (!cs1 && !oe1) ? mem1[adr1] : 8'hEE;

  sram_arbiter u0 (
    .clk100(clk), .reset(rst),
    .cpu_req(cpu_req0), .cpu_rnw(cpu_rnw0), .cpu_addr(cpu_addr0),
    .cpu_wdata(cpu_wdata0), .cpu_rdata(cpu_rdata0), .cpu_ack(cpu_ack0),
    .vid_req(vid_req0), .vid_addr(vid_addr0),
    .vid_rdata(vid_rdata0), .vid_ack(vid_ack0),
    .RAMCS_b(cs0), .RAMOE_b(oe0), .RAMWE_b(we0), .ADR(adr0),
    .dat_out(dout0), .dat_oe(doe0), .dat_in(din0)
  );

  sram_arbiter #(.RD_CYCLES(1), .WE_CYCLES(4)) u1 (
    .clk100(clk), .reset(rst),
    .cpu_req(cpu_req1), .cpu_rnw(cpu_rnw1), .cpu_addr(cpu_addr1),
    .cpu_wdata(cpu_wdata1), .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1),
    .vid_req(vid_req1), .vid_addr(vid_addr1),
    .vid_rdata(vid_rdata1), .vid_ack(vid_ack1),
    .RAMCS_b(cs1), .RAMOE_b(oe1), .RAMWE_b(we1), .ADR(adr1),
    .dat_out(dout1), .dat_oe(doe1), .dat_in(din1)
  );

  typedef struct {
    bit          rnw;
    logic [17:0] addr;
    logic [7:0]  wdata;
    bit          pre;
    logic [7:0]  pre_val;
    logic [7:0]  exp_rd;
    int          exp_oe;
    int          exp_we;
    int          exp_n;
  } vec_t;

  vec_t tbl [8];

  int vec = 0;
  int bad = 0;
  int oe_lo0 = 0, we_lo0 = 0, vack_n0 = 0, cack_n0 = 0;
  int oe_lo1 = 0, we_lo1 = 0;
  logic [7:0] refm [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cpu_txn(input bit d1, input bit rnw,
                         input logic [AW-1:0] addr, input logic [7:0] wd,
                         output int n, output logic [7:0] rd,
                         output logic doe_at_ack);
    logic ack;
    if (d1) begin
      cpu_rnw1 = rnw; cpu_addr1 = addr; cpu_wdata1 = wd; cpu_req1 = 1'b1;
    end else begin
      cpu_rnw0 = rnw; cpu_addr0 = addr; cpu_wdata0 = wd; cpu_req0 = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      ack = d1 ? cpu_ack1 : cpu_ack0;
    end while (!ack && n < 40);
    if (!ack) chk("cpu_ack_timeout", 32'(n), 32'd0);
    rd         = d1 ? cpu_rdata1 : cpu_rdata0;
    doe_at_ack = d1 ? doe1 : doe0;
    if (d1) cpu_req1 = 1'b0;
    else    cpu_req0 = 1'b0;
  endtask

  int         n, k, s_oe, s_we, s_va, s_ca, prev;
  int         t [2];
  logic [7:0] rd;
  logic       dack;
  logic [3:0] ord;

  initial begin
    tbl[0] = '{1, 18'h00123, 8'h00, 1, 8'h5A, 8'h5A, 2, 0, 3};
    tbl[1] = '{0, 18'h3FFFF, 8'hA5, 0, 8'h00, 8'h00, 0, 2, 4};
    tbl[2] = '{1, 18'h3FFFF, 8'h00, 0, 8'h00, 8'hA5, 2, 0, 3};
    tbl[3] = '{0, 18'h00000, 8'h3C, 0, 8'h00, 8'h00, 0, 2, 4};
    tbl[4] = '{1, 18'h00000, 8'h00, 0, 8'h00, 8'h3C, 2, 0, 3};
    tbl[5] = '{1, 18'h2AAAA, 8'h00, 1, 8'hC3, 8'hC3, 2, 0, 3};
    tbl[6] = '{0, 18'h15555, 8'h00, 1, 8'hFF, 8'h00, 0, 2, 4};
    tbl[7] = '{1, 18'h15555, 8'h00, 0, 8'h00, 8'h00, 2, 0, 3};

    rst = 1'b1;
    cpu_req0 = 0; cpu_rnw0 = 1; cpu_addr0 = '0; cpu_wdata0 = '0;
    vid_req0 = 0; vid_addr0 = '0;
    cpu_req1 = 0; cpu_rnw1 = 1; cpu_addr1 = '0; cpu_wdata1 = '0;
    vid_req1 = 0; vid_addr1 = '0;

    fork
      forever begin
        @(negedge clk);
        if (!oe0) oe_lo0++;
        if (!we0) we_lo0++;
        if (vid_ack0) vack_n0++;
        if (cpu_ack0) cack_n0++;
        if (!oe1) oe_lo1++;
        if (!we1) we_lo1++;
        if (!oe0 && !we0) chk("oe_we_overlap", 32'd1, 32'd0);
        if (doe0 && !oe0) chk("doe_while_oe", 32'd1, 32'd0);
        if (cpu_ack0 && vid_ack0) chk("dual_ack", 32'd1, 32'd0);
      end
      forever begin
        @(posedge clk);
        if (!cs0 && !we0 && doe0) mem0[adr0] = dout0;
        if (!cs1 && !we1 && doe1) mem1[adr1] = dout1;
      end
    join_none

    mem0[18'h00123] = 8'h5A;
    mem0[18'h00200] = 8'h3E;
    mem1[18'h00010] = 8'h99;

    repeat (2) @(negedge clk);
    chk("rst_strobes", {cs0, oe0, we0, doe0, cpu_ack0, vid_ack0}, 6'b111000);
    chk("rst_adr", adr0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_rdata", {cpu_rdata0, vid_rdata0}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Both requesters held high from reset: video first, then alternation.
    cpu_rnw0 = 1; cpu_addr0 = 18'h00123; vid_addr0 = 18'h00200;
    cpu_req0 = 1; vid_req0 = 1;
    k = 0; n = 0; ord = '0;
    while (k < 4 && n < 80) begin
      @(negedge clk);
      n++;
      if (vid_ack0) begin
        ord[k[1:0]] = 1'b1;
        chk("alt_vid_rdata", vid_rdata0, 8'h3E);
        k++;
      end else if (cpu_ack0) begin
        ord[k[1:0]] = 1'b0;
        chk("alt_cpu_rdata", cpu_rdata0, 8'h5A);
        k++;
      end
    end
    cpu_req0 = 0; vid_req0 = 0;
    chk("alt_count", 32'(k), 32'd4);
    chk("alt_order", ord, 4'b0101);
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].pre) mem0[tbl[i].addr] = tbl[i].pre_val;
      s_oe = oe_lo0; s_we = we_lo0; s_va = vack_n0;
      cpu_txn(0, tbl[i].rnw, tbl[i].addr, tbl[i].wdata, n, rd, dack);
      @(negedge clk);
      chk($sformatf("v%0d_occ", i), 32'(n + 1), 32'(tbl[i].exp_n + 1));
      chk($sformatf("v%0d_oe_w", i), 32'(oe_lo0 - s_oe), 32'(tbl[i].exp_oe));
      chk($sformatf("v%0d_we_w", i), 32'(we_lo0 - s_we), 32'(tbl[i].exp_we));
      chk($sformatf("v%0d_vack", i), 32'(vack_n0 - s_va), 32'd0);
      if (tbl[i].rnw) begin
        chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
      end else begin
        chk($sformatf("v%0d_doe_ack", i), dack, 1'b1);
        chk($sformatf("v%0d_doe_rel", i), doe0, 1'b0);
        chk($sformatf("v%0d_mem", i), mem0[tbl[i].addr], tbl[i].wdata);
      end
    end

    // Video holds req across its ack; then CPU joins and must go next.
    vid_addr0 = 18'h00200; vid_req0 = 1;
    k = 0; n = 0; prev = 0;
    while (k < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (vid_ack0) begin
        if (prev != 0) chk("vid_dup_ack", 32'd1, 32'd0);
        t[k[0]] = n;
        k++;
      end
      prev = int'(vid_ack0);
    end
    chk("b2b_count", 32'(k), 32'd2);
    chk("b2b_spacing", 32'(t[1] - t[0]), 32'd4);
    cpu_rnw0 = 1; cpu_addr0 = 18'h00123; cpu_req0 = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack0 && !vid_ack0 && n < 40);
    chk("no_starve_cpu", {cpu_ack0, vid_ack0}, 2'b10);
    cpu_req0 = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vid_ack0 && n < 40);
    chk("vid_after_cpu", vid_ack0, 1'b1);
    vid_req0 = 0;
    repeat (2) @(negedge clk);

    // Reset in the middle of the write pulse.
    s_ca = cack_n0;
    cpu_rnw0 = 0; cpu_addr0 = 18'h00042; cpu_wdata0 = 8'h77; cpu_req0 = 1;
    n = 0;
    while (we0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("we_reached", we0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_we", we0, 1'b1);
    chk("rst_mid_doe", doe0, 1'b0);
    chk("rst_mid_cs", cs0, 1'b1);
    cpu_req0 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_noack", 32'(cack_n0 - s_ca), 32'd0);
    cpu_txn(0, 1, 18'h00123, 8'h00, n, rd, dack);
    chk("post_rst_rd", rd, 8'h5A);
    chk("post_rst_lat", 32'(n), 32'd3);
    @(negedge clk);

    // RD_CYCLES=1, WE_CYCLES=4 variant.
    s_oe = oe_lo1;
    cpu_txn(1, 1, 18'h00010, 8'h00, n, rd, dack);
    @(negedge clk);
    chk("p_rd_occ", 32'(n + 1), 32'd3);
    chk("p_rd_oe_w", 32'(oe_lo1 - s_oe), 32'd1);
    chk("p_rd_data", rd, 8'h99);
    s_we = we_lo1; s_oe = oe_lo1;
    cpu_txn(1, 0, 18'h00020, 8'h44, n, rd, dack);
    @(negedge clk);
    chk("p_wr_occ", 32'(n + 1), 32'd7);
    chk("p_wr_we_w", 32'(we_lo1 - s_we), 32'd4);
    chk("p_wr_oe_w", 32'(oe_lo1 - s_oe), 32'd0);
    chk("p_wr_mem", mem1[18'h00020], 8'h44);

    // Random traffic over a small window against a byte-array model.
    for (int i = 0; i < 16; i++) begin
      refm[i] = 8'($urandom);
      cpu_txn(0, 0, BASE + 18'(i), refm[i], n, rd, dack);
    end
    @(negedge clk);
    fork
      begin : cpu_p
        int g, a, cn;
        bit r;
        logic [7:0] w, crd;
        logic cdk;
        for (int i = 0; i < 40; i++) begin
          g = $urandom_range(0, 3);
          repeat (g) @(negedge clk);
          a = $urandom_range(0, 15);
          r = 1'($urandom_range(0, 1));
          w = 8'($urandom);
          cpu_txn(0, r, BASE + 18'(a), w, cn, crd, cdk);
          chk("rnd_cpu_lat", 32'(cn <= 9), 32'd1);
          if (r) chk("rnd_cpu_rdata", crd, refm[a]);
          else refm[a] = w;
        end
      end
      begin : vid_p
        int g, a, vn;
        for (int i = 0; i < 40; i++) begin
          g = $urandom_range(0, 3);
          repeat (g) @(negedge clk);
          a = $urandom_range(0, 15);
          vid_addr0 = BASE + 18'(a);
          vid_req0 = 1;
          vn = 0;
          do begin
            @(negedge clk);
            vn++;
          end while (!vid_ack0 && vn < 40);
          chk("rnd_vid_ack", vid_ack0, 1'b1);
          chk("rnd_vid_lat", 32'(vn <= 9), 32'd1);
          chk("rnd_vid_rdata", vid_rdata0, refm[a]);
          vid_req0 = 0;
        end
      end
    join
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
